// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Signal bundle between the IF/ID register, the hazard
//                scheduler and the ID stage.
//                master : pipeline side (drives instr_in, br_taken)
//                slave  : hazard_ctrl (drives instruction, holds, selects,
//                         debug state and performance counters)
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if;
   logic [31:0] instr_in;
   logic        br_taken;
   logic [31:0] instr_out;
   logic        pc_hold;
   logic        ifid_hold;
   logic [2:0]  ld_rs_fwd;
   logic [2:0]  ld_rt_fwd;
   logic [1:0]  state_out;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output instr_in, br_taken,
      input  instr_out, pc_hold, ifid_hold, ld_rs_fwd, ld_rt_fwd,
             state_out, stall_cnt, flush_cnt
   );

   modport slave (
      input  instr_in, br_taken,
      output instr_out, pc_hold, ifid_hold, ld_rs_fwd, ld_rt_fwd,
             state_out, stall_cnt, flush_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Load-use hazard detection and bubble scheduling between the
//                IF/ID register and ID. Stalls PC and IF/ID for one cycle on
//                a load-use hazard, produces load-forward selects for the
//                instruction handed to ID, and squashes wrong-path
//                instructions after a JUMP or a taken BEQ.
//  Ports       : clk, rst (sync, active-high)
//                bus.instr_in / bus.br_taken         inputs
//                bus.instr_out, pc_hold, ifid_hold   ID-side outputs
//                bus.ld_rs_fwd / ld_rt_fwd           load-forward selects
//                bus.state_out                       FSM state (debug)
//                bus.stall_cnt / flush_cnt           performance counters
//  Parameters  : BR_FLUSH  total bubbles after br_taken (1..7)
//                JMP_FLUSH bubbles after a JUMP is passed to ID (0..7)
//  Macro       : HAZ_PERF_CNT_EN enables the saturating stall/flush counters;
//                when undefined both counters read 16'd0.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int BR_FLUSH  = 2,
   parameter int JMP_FLUSH = 1
) (
   input  wire logic   clk,
   input  wire logic   rst,
   hazard_ctrl_if.slave bus
);

   localparam logic [5:0]  c_OP_ADD   = 6'h01;
   localparam logic [5:0]  c_OP_LDW   = 6'h02;
   localparam logic [5:0]  c_OP_SDW   = 6'h03;
   localparam logic [5:0]  c_OP_BEQ   = 6'h04;
   localparam logic [5:0]  c_OP_JUMP  = 6'h05;
   localparam logic [5:0]  c_OP_STALL = 6'h3F;
   localparam logic [31:0] c_BUBBLE   = {c_OP_STALL, 26'd0};
   localparam logic [5:0]  c_H_INV    = 6'd32;

   // The br_taken cycle is itself the first bubble, so FLUSH only has to
   // supply BR_FLUSH-1 more; fcnt counts the FLUSH cycles left after this one.
   localparam logic [2:0] c_BR_LOAD  = (BR_FLUSH > 1)  ? 3'(BR_FLUSH - 2)  : 3'd0;
   localparam logic [2:0] c_JMP_LOAD = (JMP_FLUSH > 0) ? 3'(JMP_FLUSH - 1) : 3'd0;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_fcnt, w_fcnt_nxt;
   logic [5:0]  r_h1, r_h2, r_h3;
   logic [31:0] w_out, w_instr_out;
   logic        w_hold, w_flush_bub, w_hazard;

   // rt sits in [25:21] for the I-format ops, otherwise in [15:11]
   function automatic logic [4:0] f_rt(input logic [31:0] i);
      logic [5:0] op;
      op = i[31:26];
      if (op == c_OP_SDW || op == c_OP_BEQ || op == c_OP_LDW) return i[25:21];
      return i[15:11];
   endfunction

   // LDW's rt field is its destination, not a source
   function automatic logic f_rt_read(input logic [5:0] op);
      return !(op == c_OP_LDW || op == c_OP_JUMP || op == c_OP_STALL);
   endfunction

   function automatic logic f_rs_read(input logic [5:0] op);
      return !(op == c_OP_JUMP || op == c_OP_STALL);
   endfunction

   assign w_hazard = !r_h1[5] && f_rs_read(bus.instr_in[31:26]) &&
                     ((bus.instr_in[20:16] == r_h1[4:0]) ||
                      (f_rt_read(bus.instr_in[31:26]) && f_rt(bus.instr_in) == r_h1[4:0]));

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_out       = c_BUBBLE;
      w_hold      = 1'b0;
      w_flush_bub = 1'b0;
      if (bus.br_taken) begin
         // taken branch overrides every state, including a pending hazard
         w_flush_bub = 1'b1;
         w_fcnt_nxt  = c_BR_LOAD;
         w_state_nxt = (BR_FLUSH > 1) ? FLUSH : RUN;
      end else begin
         case (r_state)
            RUN: begin
               if (w_hazard) begin
                  w_hold      = 1'b1;
                  w_state_nxt = LDSTALL;
               end else if (bus.instr_in[31:26] == c_OP_JUMP) begin
                  w_out = bus.instr_in;
                  if (JMP_FLUSH > 0) begin
                     w_fcnt_nxt  = c_JMP_LOAD;
                     w_state_nxt = FLUSH;
                  end
               end else begin
                  w_out = bus.instr_in;
               end
            end
            LDSTALL: begin
               w_out       = bus.instr_in;
               w_state_nxt = RUN;
            end
            FLUSH: begin
               w_flush_bub = 1'b1;
               if (r_fcnt == 3'd0) w_state_nxt = RUN;
               else                w_fcnt_nxt  = r_fcnt - 3'd1;
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   assign w_instr_out   = rst ? c_BUBBLE : w_out;
   assign bus.instr_out = w_instr_out;
   assign bus.pc_hold   = w_hold && !rst;
   assign bus.ifid_hold = w_hold && !rst;
   assign bus.state_out = rst ? RUN : r_state;

   // Forward selects refer to the loads now in MEM (h2) and WB (h3)
   always_comb begin
      bus.ld_rs_fwd = 3'd0;
      bus.ld_rt_fwd = 3'd0;
      if (f_rs_read(w_instr_out[31:26])) begin
         if (!r_h2[5] && w_instr_out[20:16] == r_h2[4:0])      bus.ld_rs_fwd = 3'd1;
         else if (!r_h3[5] && w_instr_out[20:16] == r_h3[4:0]) bus.ld_rs_fwd = 3'd2;
      end
      if (f_rt_read(w_instr_out[31:26])) begin
         if (!r_h2[5] && f_rt(w_instr_out) == r_h2[4:0])      bus.ld_rt_fwd = 3'd1;
         else if (!r_h3[5] && f_rt(w_instr_out) == r_h3[4:0]) bus.ld_rt_fwd = 3'd2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
         r_fcnt  <= 3'd0;
         r_h1    <= c_H_INV;
         r_h2    <= c_H_INV;
         r_h3    <= c_H_INV;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_h3    <= r_h2;
         r_h2    <= r_h1;
         r_h1    <= (w_instr_out[31:26] == c_OP_LDW) ? {1'b0, w_instr_out[25:21]} : c_H_INV;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [15:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else begin
         if (w_hold && r_stall_cnt != 16'hFFFF)      r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_flush_bub && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;
`else
   assign bus.stall_cnt = 16'd0;
   assign bus.flush_cnt = 16'd0;
`endif

   // c_OP_ADD documents the R-format opcode used by the pipeline
   logic w_unused;
   assign w_unused = ^c_OP_ADD;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl. Instance A
//                uses BR_FLUSH=2/JMP_FLUSH=1, instance B BR_FLUSH=3/JMP_FLUSH=0;
//                both see the same stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam logic [5:0]  c_OP_ADD   = 6'h01;
   localparam logic [5:0]  c_OP_LDW   = 6'h02;
   localparam logic [5:0]  c_OP_SDW   = 6'h03;
   localparam logic [5:0]  c_OP_JUMP  = 6'h05;
   localparam logic [31:0] c_BUB      = {6'h3F, 26'd0};
   localparam logic [31:0] c_JMP      = {c_OP_JUMP, 26'h3FFFFFF};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if bus_a ();
   hazard_ctrl_if bus_b ();

   hazard_ctrl #(.BR_FLUSH(2), .JMP_FLUSH(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   hazard_ctrl #(.BR_FLUSH(3), .JMP_FLUSH(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   function automatic logic [31:0] f_ldw(input logic [4:0] d, input logic [4:0] b);
      return {c_OP_LDW, d, b, 16'h0};
   endfunction
   function automatic logic [31:0] f_add(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
      return {c_OP_ADD, d, s, t, 11'h0};
   endfunction
   function automatic logic [31:0] f_sdw(input logic [4:0] t, input logic [4:0] b);
      return {c_OP_SDW, t, b, 16'h0};
   endfunction
   // counter expectation: real value with the feature, zero without
   function automatic logic [31:0] f_pc(input int v);
`ifdef HAZ_PERF_CNT_EN
      return 32'(v);
`else
      return (v == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // one cycle: drive after the edge, settle, sample at the falling edge
   task automatic cyc(input logic [31:0] ins, input logic br, input logic r);
      @(posedge clk);
      #1;
      rst            = r;
      bus_a.instr_in = ins;  bus_a.br_taken = br;
      bus_b.instr_in = ins;  bus_b.br_taken = br;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus_a.instr_in = f_add(6, 7, 8);  bus_a.br_taken = 1'b0;
      bus_b.instr_in = f_add(6, 7, 8);  bus_b.br_taken = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_instr",  bus_a.instr_out, c_BUB);
      check("rst_hold",   {bus_a.pc_hold, bus_a.ifid_hold}, 0);
      check("rst_state",  bus_a.state_out, 0);
      check("rst_fwd",    {bus_a.ld_rs_fwd, bus_a.ld_rt_fwd}, 0);
      check("rst_cnt",    {bus_a.stall_cnt, bus_a.flush_cnt}, 0);
      cyc(c_BUB, 1'b0, 1'b0);

      // load-use on rs
      cyc(f_ldw(3, 1), 1'b0, 1'b0);
      check("t1_ldw",     bus_a.instr_out, f_ldw(3, 1));
      cyc(f_add(4, 3, 2), 1'b0, 1'b0);
      check("t1_hold",    {bus_a.pc_hold, bus_a.ifid_hold}, 2'b11);
      check("t1_bub",     bus_a.instr_out, c_BUB);
      cyc(f_add(4, 3, 2), 1'b0, 1'b0);
      check("t1_add",     bus_a.instr_out, f_add(4, 3, 2));
      check("t1_nohold",  bus_a.pc_hold, 0);
      check("t1_state",   bus_a.state_out, 1);
      check("t1_rsfwd",   bus_a.ld_rs_fwd, 1);
      check("t1_rtfwd",   bus_a.ld_rt_fwd, 0);
      check("t1_scnt",    bus_a.stall_cnt, f_pc(1));

      // forwarding distance 2 and 3 on rt
      cyc(f_ldw(5, 1), 1'b0, 1'b0);
      check("t2_ldw",     bus_a.instr_out, f_ldw(5, 1));
      cyc(f_add(6, 7, 8), 1'b0, 1'b0);
      cyc(f_sdw(5, 1), 1'b0, 1'b0);
      check("t2_nohold",  bus_a.pc_hold, 0);
      check("t2_rtfwd1",  bus_a.ld_rt_fwd, 1);
      check("t2_rsfwd1",  bus_a.ld_rs_fwd, 0);
      cyc(f_ldw(9, 1), 1'b0, 1'b0);
      cyc(f_add(6, 7, 8), 1'b0, 1'b0);
      cyc(f_add(10, 7, 8), 1'b0, 1'b0);
      cyc(f_sdw(9, 1), 1'b0, 1'b0);
      check("t2_rtfwd2",  bus_a.ld_rt_fwd, 2);
      check("t2_instr",   bus_a.instr_out, f_sdw(9, 1));

      // load-use through rt of a store
      cyc(f_ldw(11, 1), 1'b0, 1'b0);
      cyc(f_sdw(11, 1), 1'b0, 1'b0);
      check("t2_rthaz",   bus_a.pc_hold, 1);
      cyc(f_sdw(11, 1), 1'b0, 1'b0);
      check("t2_rtrel",   bus_a.instr_out, f_sdw(11, 1));
      check("t2_rtfwd",   bus_a.ld_rt_fwd, 1);

      // back-to-back loads to the same dest: LDW rt is not a source
      cyc(f_ldw(12, 1), 1'b0, 1'b0);
      cyc(f_ldw(12, 2), 1'b0, 1'b0);
      check("t2_ldld",    bus_a.pc_hold, 0);
      check("t2_ldldi",   bus_a.instr_out, f_ldw(12, 2));

      // taken branch
      cyc(f_add(6, 7, 8), 1'b1, 1'b0);
      check("t3_bub0",    bus_a.instr_out, c_BUB);
      check("t3_hold0",   bus_a.pc_hold, 0);
      cyc(f_add(6, 7, 8), 1'b0, 1'b0);
      check("t3_bub1",    bus_a.instr_out, c_BUB);
      check("t3_st1",     bus_a.state_out, 2);
      check("t3_hold1",   {bus_a.pc_hold, bus_a.ifid_hold}, 0);
      cyc(f_add(13, 7, 8), 1'b0, 1'b0);
      check("t3_run",     bus_a.instr_out, f_add(13, 7, 8));
      check("t3_st2",     bus_a.state_out, 0);
      check("t3_fcnt",    bus_a.flush_cnt, f_pc(2));
      check("t3_b_bub",   bus_b.instr_out, c_BUB);

      // JUMP right after a load whose dest matches every jump field
      cyc(f_ldw(31, 1), 1'b0, 1'b0);
      cyc(c_JMP, 1'b0, 1'b0);
      check("t4_jmp",     bus_a.instr_out, c_JMP);
      check("t4_hold",    bus_a.pc_hold, 0);
      check("t4_fwd",     {bus_a.ld_rs_fwd, bus_a.ld_rt_fwd}, 0);
      check("t4_jmp_b",   bus_b.instr_out, c_JMP);
      cyc(f_add(6, 7, 8), 1'b0, 1'b0);
      check("t4_bub",     bus_a.instr_out, c_BUB);
      check("t4_st",      bus_a.state_out, 2);
      check("t4_nobub_b", bus_b.instr_out, f_add(6, 7, 8));
      check("t4_st_b",    bus_b.state_out, 0);
      cyc(f_add(6, 7, 8), 1'b0, 1'b0);
      check("t4_run",     bus_a.instr_out, f_add(6, 7, 8));
      check("t4_fcnt",    bus_a.flush_cnt, f_pc(3));
      check("t4_fcnt_b",  bus_b.flush_cnt, f_pc(3));

      // hazard and branch in the same cycle
      cyc(f_ldw(14, 1), 1'b0, 1'b0);
      cyc(f_add(15, 14, 8), 1'b1, 1'b0);
      check("t5_bub",     bus_a.instr_out, c_BUB);
      check("t5_hold",    {bus_a.pc_hold, bus_a.ifid_hold}, 0);
      cyc(f_add(15, 14, 8), 1'b0, 1'b0);
      check("t5_st",      bus_a.state_out, 2);
      check("t5_bub1",    bus_a.instr_out, c_BUB);
      cyc(f_ldw(20, 1), 1'b0, 1'b0);
      check("t5_run",     bus_a.instr_out, f_ldw(20, 1));
      check("t5_fcnt",    bus_a.flush_cnt, f_pc(5));
      check("t5_st_b",    bus_b.state_out, 2);

      // reset while B is in FLUSH with one more FLUSH cycle pending
      cyc(f_add(6, 7, 8), 1'b1, 1'b0);
      cyc(f_add(6, 7, 8), 1'b0, 1'b1);
      check("t6_rst_st",  bus_b.state_out, 0);
      check("t6_rst_i",   bus_b.instr_out, c_BUB);
      check("t6_rst_h",   bus_b.pc_hold, 0);
      cyc(f_add(18, 20, 8), 1'b0, 1'b0);
      check("t6_st_b",    bus_b.state_out, 0);
      check("t6_pass_b",  bus_b.instr_out, f_add(18, 20, 8));
      check("t6_fwd_a",   bus_a.ld_rs_fwd, 0);
      check("t6_cnt",     {bus_a.stall_cnt, bus_a.flush_cnt}, 0);
      cyc(f_ldw(21, 1), 1'b0, 1'b0);
      cyc(f_add(22, 21, 8), 1'b0, 1'b0);
      check("t6_stall_a", bus_a.pc_hold, 1);
      check("t6_stall_b", bus_b.pc_hold, 1);
      cyc(f_add(22, 21, 8), 1'b0, 1'b0);
      check("t6_once_a",  bus_a.pc_hold, 0);
      check("t6_once_b",  bus_b.pc_hold, 0);
      check("t6_add",     bus_a.instr_out, f_add(22, 21, 8));
      check("t6_rsfwd",   bus_a.ld_rs_fwd, 1);
      check("t6_scnt",    bus_a.stall_cnt, f_pc(1));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
